// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - raster-scan frame controller with rgb2i + threshold pipeline
module frame_sequencer #(
    parameter int WIDTH   = 8,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int XW      = $clog2(FRAME_W),
    parameter int YW      = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] thresh,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic [WIDTH-1:0] out_gray,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof
);

    localparam int              SW      = WIDTH + 2;
    localparam logic [WIDTH-1:0] PIX_MAX = '1;
    localparam logic [WIDTH-1:0] PIX_MIN = '0;
    localparam logic [XW-1:0]    X_LAST  = XW'(FRAME_W - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(FRAME_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             start_ok;
    logic             advance;
    logic             s2_en;
    logic             accept;
    logic [WIDTH-1:0] thr_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_gray;
    logic [XW-1:0]    s1_x;
    logic [YW-1:0]    s1_y;

    // Luma approximation 0.281R + 0.5625G + 0.094B from truncating shifts;
    // the sum never exceeds 234/255 of full scale, so the low WIDTH bits suffice.
    function automatic logic [WIDTH-1:0] rgb2i(input logic [WIDTH-1:0] r,
                                               input logic [WIDTH-1:0] g,
                                               input logic [WIDTH-1:0] b);
        logic [SW-1:0] sum;
        sum = SW'(r >> 2) + SW'(r >> 5) + SW'(g >> 1) + SW'(g >> 4)
            + SW'(b >> 4) + SW'(b >> 5);
        return sum[WIDTH-1:0];
    endfunction

    // Handshake qualifiers and frame-level next state.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        s2_en    = !out_valid || out_ready;
        advance  = !s1_valid || s2_en;
        in_ready = (state_q == ST_RUN) && advance;
        accept   = in_valid && in_ready;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    start_ok = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept && (x_q == X_LAST) && (y_q == Y_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && out_eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-frame threshold latch and raster position of the next accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (start_ok) begin
            thr_q <= thresh;
            x_q   <= '0;
            y_q   <= '0;
        end else if (accept) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Stage 1: intensity plus position; empties into stage 2 or takes a new pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_gray <= rgb2i(in_r, in_g, in_b);
                s1_x    <= x_q;
                s1_y    <= y_q;
            end
        end
    end

    // Stage 2: threshold and frame markers; data only moves on a real transfer so
    // the outputs hold while stalled or empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_bin   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_gray <= s1_gray;
                out_bin  <= (s1_gray > thr_q) ? PIX_MAX : PIX_MIN;
                out_x    <= s1_x;
                out_y    <= s1_y;
                out_sof  <= (s1_x == '0) && (s1_y == '0);
                out_eol  <= (s1_x == X_LAST);
                out_eof  <= (s1_x == X_LAST) && (s1_y == Y_LAST);
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - frame-level model and directed frames for frame_sequencer
module tb_frame_sequencer;

    localparam int W  = 8;
    localparam int FW = 4;
    localparam int FH = 2;
    localparam int NP = FW * FH;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] thresh = '0;
    logic         busy, done;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_bin, out_gray;
    logic [1:0]   out_x;
    logic [0:0]   out_y;
    logic         out_sof, out_eol, out_eof;

    frame_sequencer #(.WIDTH(W), .FRAME_W(FW), .FRAME_H(FH), .XW(2), .YW(1)) dut (
        .clk(clk), .reset(reset), .start(start), .thresh(thresh),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_gray(out_gray),
        .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gray;
        int bin;
        int x;
        int y;
        int sof;
        int eol;
        int eof;
    } exp_t;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    int   mode = M_IDLE;
    int   thr_m = 0;
    int   mx = 0, my = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    int   first_gray = -1;
    int   first_bin = -1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int luma(input int r, input int g, input int b);
        return r / 4 + r / 32 + g / 2 + g / 16 + b / 16 + b / 32;
    endfunction

    // Model and compare: checks what the DUT shows this cycle, then applies what the
    // coming edge will do with the inputs visible now.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mode = M_IDLE;
            mx   = 0;
            my   = 0;
        end else begin
            int   m0;
            exp_t e;
            m0 = mode;
            check("busy", int'(busy), int'(m0 == M_RUN || m0 == M_DRAIN));
            check("done", int'(done), int'(m0 == M_DONE));
            check("in_ready", int'(in_ready),
                  int'(m0 == M_RUN && (q.size() < 2 || out_ready)));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    e = q[0];
                    check("out_gray", int'(out_gray), e.gray);
                    check("out_bin",  int'(out_bin),  e.bin);
                    check("out_x",    int'(out_x),    e.x);
                    check("out_y",    int'(out_y),    e.y);
                    check("out_sof",  int'(out_sof),  e.sof);
                    check("out_eol",  int'(out_eol),  e.eol);
                    check("out_eof",  int'(out_eof),  e.eof);
                end
            end
            if (m0 == M_DONE) begin
                done_cnt++;
                mode = M_IDLE;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                out_cnt++;
                if (e.sof != 0) begin
                    first_gray = e.gray;
                    first_bin  = e.bin;
                end
                if (e.eof != 0 && m0 == M_DRAIN) mode = M_DONE;
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                e.gray = luma(int'(in_r), int'(in_g), int'(in_b));
                e.bin  = (e.gray > thr_m) ? 255 : 0;
                e.x    = mx;
                e.y    = my;
                e.sof  = int'(mx == 0 && my == 0);
                e.eol  = int'(mx == FW - 1);
                e.eof  = int'(mx == FW - 1 && my == FH - 1);
                q.push_back(e);
                if (mx == FW - 1) begin
                    mx = 0;
                    if (my == FH - 1) begin
                        my   = 0;
                        mode = M_DRAIN;
                    end else begin
                        my++;
                    end
                end else begin
                    mx++;
                end
            end
            if (start && m0 == M_IDLE) begin
                mode  = M_RUN;
                thr_m = int'(thresh);
                mx    = 0;
                my    = 0;
            end
        end
    end

    task automatic set_pix(input int idx, input int cmode);
        if (cmode == 0) begin
            in_r = 8'd200;
            in_g = 8'd200;
            in_b = 8'd200;
        end else begin
            in_r = W'((idx * 37 + 11) & 255);
            in_g = W'((idx * 53 + 90) & 255);
            in_b = W'((idx * 91 + 5) & 255);
        end
    endtask

    task automatic run_frame(input int thr, input int npix, input int cmode,
                             input int st_lo, input int st_hi, input int ms_cyc);
        int idx;
        int cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        @(posedge clk); #1;
        start  = 1'b1;
        thresh = W'(thr);
        @(posedge clk); #1;
        start    = 1'b0;
        set_pix(0, cmode);
        in_valid = 1'b1;
        while (idx < npix && cyc < 200) begin
            out_ready = !(cyc >= st_lo && cyc < st_hi);
            start     = (cyc == ms_cyc);
            if (cyc == ms_cyc) thresh = '0;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                set_pix(idx, cmode);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 200) check("accept_timeout", idx, npix);
    endtask

    task automatic wait_done;
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_pulses", done_cnt - d0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, o0, d0;
        // 1: reset state, then valid pixels while idle are never taken
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready),  0);
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        check("rst_out_bin",   int'(out_bin),   0);
        check("rst_out_gray",  int'(out_gray),  0);
        check("rst_out_xy",    int'({out_x, out_y}), 0);
        check("rst_markers",   int'({out_sof, out_eol, out_eof}), 0);
        in_valid = 1'b1;
        set_pix(0, 0);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_accepts", acc_cnt, 0);

        // 2: gray 186 above threshold 185
        o0 = out_cnt;
        run_frame(185, NP, 0, -1, -1, -1);
        wait_done();
        check("t2_first_gray", first_gray, 186);
        check("t2_first_bin",  first_bin,  255);
        check("t2_out_count",  out_cnt - o0, NP);

        // 3: equality maps to MIN
        first_bin = -1;
        run_frame(186, NP, 0, -1, -1, -1);
        wait_done();
        check("t3_first_bin", first_bin, 0);

        // 4: three-cycle downstream stall mid-frame
        o0 = out_cnt;
        run_frame(120, NP, 1, 3, 6, -1);
        wait_done();
        check("t4_out_count", out_cnt - o0, NP);

        // 5: start and thresh change during RUN are ignored
        o0 = out_cnt;
        run_frame(100, NP, 1, -1, -1, 2);
        wait_done();
        check("t5_out_count", out_cnt - o0, NP);

        // 6: reset after three accepts, then a clean frame
        a0 = acc_cnt;
        run_frame(120, 3, 1, -1, -1, -1);
        check("t6_partial_accepts", acc_cnt - a0, 3);
        d0 = done_cnt;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_busy",      int'(busy),      0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - d0, 0);
        o0 = out_cnt;
        first_gray = -1;
        run_frame(90, NP, 1, -1, -1, -1);
        wait_done();
        check("t6_out_count", out_cnt - o0, NP);
        check("t6_first_gray", first_gray, luma(11, 90, 5));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
